// File: rtl/mem_pkg.sv
// Shared types and constants for the memory command queue.
// State encodings, direction constants and entry sizing.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    // One queued command packs {wr_rd, addr, wdata}.
    function automatic int entry_width(int aw, int w);
        return 1 + aw + w;
    endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO, registered occupancy.
// Head is the oldest entry; a push is seen one cycle later.
module mem_cmd_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // Entry storage; occupancy lives in the pointers, not the data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_cmd_queue.sv
// Client command queue and request master for a
// valid/ready single-port memory; reads return as pulses.
module mem_cmd_queue
    import mem_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    output logic                  valid,
    input  logic                  ready,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  busy
);

    localparam int EW = entry_width(ADDR_WIDTH, WIDTH);

    state_t                state;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [EW-1:0]         din;
    logic [EW-1:0]         head;
    logic                  head_wr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WIDTH-1:0]      head_wdata;

    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    assign din        = {cmd_wr_rd, cmd_addr, cmd_wdata};
    // Head leaves the FIFO only when the memory accepts it.
    assign pop        = (state == ST_ISSUE) && ready;
    assign head_wr    = head[EW-1];
    assign head_addr  = head[WIDTH +: ADDR_WIDTH];
    assign head_wdata = head[WIDTH-1:0];
    assign busy       = !empty || (state != ST_IDLE);

    mem_cmd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Issue FSM: load head, hold request until accepted,
    // then capture read data one cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            valid     <= 1'b0;
            wr_rd     <= RD;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        wr_rd <= head_wr;
                        addr  <= head_addr;
                        wdata <= head_wdata;
                        valid <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= (wr_rd == WR) ? ST_IDLE
                                               : ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    rsp_data  <= rdata;
                    rsp_addr  <= addr;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cmd_queue.sv
// Bench for mem_cmd_queue: directed table, corner
// sequences and randomized traffic against a model.
module tb_mem_cmd_queue;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr_rd;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic          valid;
    logic          ready;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    logic mem_clear;
    logic rnd;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } cmd_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic [W-1:0]  exp;
    } vec_t;

    always #5 clk = ~clk;

    mem_cmd_queue #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr_rd (cmd_wr_rd),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .valid     (valid),
        .ready     (ready),
        .wr_rd     (wr_rd),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .busy      (busy)
    );

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Memory stand-in: rdata valid the cycle after accept.
    logic [W-1:0] mem_arr [16];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
            rdata <= '0;
        end else if (valid && ready) begin
            if (wr_rd) mem_arr[addr] <= wdata;
            else       rdata <= mem_arr[addr];
        end
    end

    // Reference model: commands in order, reads answered
    // with the latest earlier write to the same address.
    cmd_t         cmdq [$];
    cmd_t         expq [$];
    logic [W-1:0] shadow [16];
    logic         rd_acc_prev;
    logic         rdw_prev;
    logic         hold_prev;
    cmd_t         hold_cmd;

    always @(negedge clk) begin
        logic rdw;
        logic acc;
        cmd_t c;
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) shadow[i] = '0;
        end
        if (!rst) begin
            cmdq.delete();
            expq.delete();
            rd_acc_prev = 1'b0;
            rdw_prev    = 1'b0;
            hold_prev   = 1'b0;
        end else begin
            rdw = rd_acc_prev;
            chk("cmd_ready", 32'(cmd_ready),
                32'(cmdq.size() < D));
            chk("busy", 32'(busy),
                32'(cmdq.size() != 0 || rdw));
            chk("rsp_valid", 32'(rsp_valid), 32'(rdw_prev));
            if (cmdq.size() == 0)
                chk("idle_valid", 32'(valid), 0);
            if (hold_prev) begin
                chk("hold_valid", 32'(valid), 1);
                chk("hold_cmd", 32'({wr_rd, addr, wdata}),
                    32'(hold_cmd));
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (expq.size() == 0) begin
                    chk("rsp_extra", 1, 0);
                end else begin
                    c = expq.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(c.d));
                    chk("rsp_addr", 32'(rsp_addr), 32'(c.a));
                end
            end
            acc = valid && ready;
            if (acc) begin
                acc_cnt++;
                if (cmdq.size() == 0) begin
                    chk("acc_extra", 1, 0);
                end else begin
                    c = cmdq.pop_front();
                    chk("acc_wr", 32'(wr_rd), 32'(c.wr));
                    chk("acc_addr", 32'(addr), 32'(c.a));
                    if (c.wr)
                        chk("acc_wdata", 32'(wdata), 32'(c.d));
                end
            end
            if (cmd_valid && cmd_ready) begin
                c = {cmd_wr_rd, cmd_addr, cmd_wdata};
                cmdq.push_back(c);
                if (cmd_wr_rd) begin
                    shadow[cmd_addr] = cmd_wdata;
                end else begin
                    c.d = shadow[cmd_addr];
                    expq.push_back(c);
                end
            end
            rd_acc_prev = acc && !wr_rd;
            rdw_prev    = rdw;
            hold_prev   = valid && !ready;
            hold_cmd    = {wr_rd, addr, wdata};
        end
    end

    task automatic rnd_ready();
        if (rnd) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_cmd(logic wr, logic [AW-1:0] a,
                            logic [W-1:0] d);
        logic got;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk);
            #1;
            rnd_ready();
        end
        cmd_valid = 1'b0;
        if (!got) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(int lim);
        logic done;
        done = 1'b0;
        for (int i = 0; i < lim && !done; i++) begin
            @(posedge clk);
            #1;
            rnd_ready();
            done = !busy && (cmdq.size() == 0);
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("exp_drained", 32'(expq.size()), 0);
    endtask

    vec_t vt [7];

    initial begin
        int a0;
        int r0;
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        mem_clear = 1'b1;
        rnd       = 1'b0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr_rd = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        ready     = 1'b0;

        vt[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
        vt[1] = '{1'b1, 4'd7,  8'h5C, 8'h00};
        vt[2] = '{1'b0, 4'd7,  8'h00, 8'h5C};
        vt[3] = '{1'b0, 4'd3,  8'h00, 8'hA5};
        vt[4] = '{1'b1, 4'd0,  8'hFF, 8'h00};
        vt[5] = '{1'b0, 4'd0,  8'h00, 8'hFF};
        vt[6] = '{1'b0, 4'd15, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_regs", 32'({wr_rd, addr, wdata}), 0);
        chk("rst_rsp", 32'({rsp_data, rsp_addr}), 0);
        mem_clear = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_valid", 32'(valid), 0);
        chk("rel_cmd_ready", 32'(cmd_ready), 1);
        chk("rel_busy", 32'(busy), 0);

        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cmd_wr_rd = vt[i].wr;
            cmd_addr  = vt[i].a;
            cmd_wdata = vt[i].wr ? vt[i].d : 8'h33;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            chk("v_nobypass", 32'(valid), 0);
            chk("v_busy", 32'(busy), 1);
            @(posedge clk);
            #1;
            chk("v_valid", 32'(valid), 1);
            chk("v_wr_rd", 32'(wr_rd), 32'(vt[i].wr));
            chk("v_addr", 32'(addr), 32'(vt[i].a));
            if (vt[i].wr)
                chk("v_wdata", 32'(wdata), 32'(vt[i].d));
            @(posedge clk);
            #1;
            chk("v_valid_drop", 32'(valid), 0);
            if (vt[i].wr) begin
                chk("v_wr_busy", 32'(busy), 0);
            end else begin
                chk("v_rsp_early", 32'(rsp_valid), 0);
                @(posedge clk);
                #1;
                chk("v_rsp_valid", 32'(rsp_valid), 1);
                chk("v_rsp_data", 32'(rsp_data),
                    32'(vt[i].exp));
                chk("v_rsp_addr", 32'(rsp_addr),
                    32'(vt[i].a));
                @(posedge clk);
                #1;
                chk("v_rsp_pulse", 32'(rsp_valid), 0);
                chk("v_rd_busy", 32'(busy), 0);
            end
        end

        ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++)
            push_cmd(1'b1, AW'(8 + i), W'(8'h10 + i));
        chk("full_ready", 32'(cmd_ready), 0);
        cmd_wr_rd = 1'b1;
        cmd_addr  = 4'd2;
        cmd_wdata = 8'hEE;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("full_hold_ready", 32'(cmd_ready), 0);
            chk("full_hold_valid", 32'(valid), 1);
            chk("full_hold_addr", 32'(addr), 8);
            chk("full_hold_wdata", 32'(wdata), 32'h10);
        end
        cmd_valid = 1'b0;
        ready = 1'b1;
        wait_idle(100);
        chk("full_acc_cnt", 32'(acc_cnt - a0), 4);

        rnd = 1'b1;
        r0 = rsp_cnt;
        for (int i = 0; i < 16; i++)
            push_cmd(1'b1, AW'(i), W'($urandom));
        for (int i = 0; i < 16; i++)
            push_cmd(1'b0, AW'(i), 8'h00);
        wait_idle(500);
        chk("sweep_rsp_cnt", 32'(rsp_cnt - r0), 16);

        for (int i = 0; i < 80; i++) begin
            push_cmd(1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)),
                     W'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                rnd_ready();
            end
        end
        wait_idle(1000);

        rnd = 1'b0;
        ready = 1'b1;
        r0 = rsp_cnt;
        push_cmd(1'b0, 4'd5, 8'h00);
        @(posedge clk);
        #1;
        chk("rw_issue", 32'(valid), 1);
        @(posedge clk);
        #1;
        chk("rw_wait", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_cmd_ready", 32'(cmd_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("arst_no_rsp", 32'(rsp_valid), 0);
        end
        chk("arst_rsp_cnt", 32'(rsp_cnt - r0), 0);
        chk("arst_idle", 32'({busy, cmd_ready}), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
